external_controls: RTL
======================

EXTERNAL_CONTROLS -- requirements
Module: external_controls

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent parallel GPIO input channels.
REQ-002 Parameter IN_W, default 4: bits per input channel.
REQ-003 Parameter OUT_W, default 8: bits per output channel.
REQ-004 Parameter STEP, default 10: scale factor applied to the accepted input code.
REQ-005 Parameter MAX_OUT, default 100: saturation ceiling of every output channel.
REQ-006 Parameter UPDATE_MS, default 100: milliseconds between sample ticks.
REQ-007 Parameter CLOCK_FREQUENCY, default 166000000: clk frequency in Hz.
REQ-008 Parameter STABLE_SAMPLES, default 3 (range 1..15): consecutive equal ticks required to accept an input.
REQ-009 Parameter SLEW, default 5 (at least 1): maximum output change per tick.
REQ-010 clk  input  1  sole clock; all state on rising edge.
REQ-011 reset  input  1  asynchronous, active-high reset.
REQ-012 gpio  input  CHANNELS*IN_W  asynchronous raw inputs; channel i occupies bits [i*IN_W +: IN_W].
REQ-013 value  output  CHANNELS*OUT_W  registered scaled outputs, same packing as gpio.
REQ-014 update  output  1  one-cycle strobe marking the cycle the outputs were refreshed.
REQ-015 changed  output  CHANNELS  per-channel strobe, valid only while update is high.

Function
REQ-016 Each gpio bit SHALL pass through a two-flop synchronizer before any other use.
REQ-017 A tick counter SHALL assert an internal tick for exactly one cycle every PERIOD = UPDATE_MS*(CLOCK_FREQUENCY/1000) cycles; first tick at cycle PERIOD-1 after reset release; the counter wraps to 0 on tick.
REQ-018 On tick, per channel: if the synchronized code equals the candidate, the stable count increments, saturating at STABLE_SAMPLES; otherwise the candidate loads the synchronized code and the count becomes 1.
REQ-019 When the stable count equals STABLE_SAMPLES, the accepted code SHALL equal the candidate; otherwise the accepted code is held.
REQ-020 Target = min(accepted*STEP, MAX_OUT), computed in width sufficient for (2^IN_W-1)*STEP with no overflow, then truncated to OUT_W.
REQ-021 The value register SHALL update exactly one cycle after tick, using the accepted code produced on that tick; update SHALL be high on that same cycle.
REQ-022 changed[i] SHALL be high in the update cycle iff value channel i differs from its previous contents; it SHALL be low whenever update is low.
REQ-023 Between updates, value SHALL hold steady regardless of gpio activity.
REQ-024 Channels SHALL be fully independent; activity on one never delays or alters another.

Reset
REQ-025 On reset assertion, immediately and asynchronously: value=0, update=0, changed=0, tick counter=0, synchronizers=0, candidates=0, stable counts=0, accepted codes=0.
REQ-026 Reset asserted mid-period or mid-slew SHALL discard all progress; after release, behaviour matches a fresh power-up.

Configuration
REQ-027 Macro EXTERNAL_CONTROLS_SLEW_EN defined: each update, value moves toward target by min(|target-value|, SLEW), upward or downward.
REQ-028 Macro EXTERNAL_CONTROLS_SLEW_EN undefined: value loads target directly on each update; parameter SLEW is ignored.

Verification (CLOCK_FREQUENCY=10000, UPDATE_MS=1 -> PERIOD=10; CHANNELS=2, STABLE_SAMPLES=3 unless stated)
REQ-029 Hold ch0 gpio=4 from reset, slew off -> update pulses every 10 cycles, first at cycle 10; value ch0=40 on the 3rd update, changed[0]=1 only then.
REQ-030 ch0 gpio=12, slew off -> value ch0 saturates at 100, never 120; gpio=9 -> 90.
REQ-031 ch0 toggles 3->5->3 each tick -> accepted never changes; value ch0 stays 0 and changed stays 0.
REQ-032 Slew on (SLEW=5), ch0 gpio 0->2 stable -> value ch0 sequence 0,5,10,15,20 on successive updates after acceptance, then holds; gpio 0 -> descends in steps of 5 to 0.
REQ-033 ch0=4, ch1=7 simultaneously -> both outputs change in the same update cycle with changed=2'b11; one channel's changes never perturb the other.
REQ-034 Assert reset for 2 cycles mid-period with value ch0=40 -> value=0, update=0 immediately; next update exactly 10 cycles after release.

Source files
------------

// File: rtl/external_controls.sv
// Debounced, scaled GPIO-to-control-value converter with periodic update strobes.
// Define EXTERNAL_CONTROLS_SLEW_EN to rate-limit each output by SLEW per update.
module external_controls #(
    parameter int CHANNELS        = 4,
    parameter int IN_W            = 4,
    parameter int OUT_W           = 8,
    parameter int STEP            = 10,
    parameter int MAX_OUT         = 100,
    parameter int UPDATE_MS       = 100,
    parameter int CLOCK_FREQUENCY = 166000000,
    parameter int STABLE_SAMPLES  = 3,
    parameter int SLEW            = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*IN_W-1:0]  gpio,
    output logic [CHANNELS*OUT_W-1:0] value,
    output logic                      update,
    output logic [CHANNELS-1:0]       changed
);

    localparam int PERIOD = UPDATE_MS * (CLOCK_FREQUENCY / 1000);
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PROD_W = IN_W + $clog2(STEP + 1);
    localparam int SLEW_W = $clog2(SLEW + 1) + 1;
    localparam int WIDE_A = (PROD_W > OUT_W + 1) ? PROD_W : OUT_W + 1;
    localparam int WIDE_B = (WIDE_A > SLEW_W) ? WIDE_A : SLEW_W;
    // Arithmetic width covers the full product, the output range, SLEW and MAX_OUT.
    localparam int CMP_W  = (WIDE_B > 31) ? WIDE_B + 1 : 32;

    logic [CNT_W-1:0]         tick_cnt;
    logic                     tick;
    logic [CHANNELS*IN_W-1:0] gpio_meta;
    logic [CHANNELS*IN_W-1:0] gpio_sync;

    logic [IN_W-1:0]  candidate  [CHANNELS];
    logic [IN_W-1:0]  accepted   [CHANNELS];
    logic [3:0]       stable_cnt [CHANNELS];
    logic [IN_W-1:0]  cand_nxt   [CHANNELS];
    logic [IN_W-1:0]  acc_nxt    [CHANNELS];
    logic [3:0]       cnt_nxt    [CHANNELS];
    logic [OUT_W-1:0] target     [CHANNELS];
    logic [OUT_W-1:0] value_nxt  [CHANNELS];

    assign tick = (tick_cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + CNT_W'(1);
            gpio_meta <= gpio;
            gpio_sync <= gpio_meta;
        end
    end

    // The accepted code from this tick feeds the value computed on the same edge,
    // so the output lands one cycle after the tick with no extra pipeline stage.
    always_comb begin
        logic [IN_W-1:0]  code;
        logic [CMP_W-1:0] prod;
        logic [CMP_W-1:0] sat;
        logic [OUT_W-1:0] cur;
        logic [CMP_W-1:0] diff;
        for (int i = 0; i < CHANNELS; i++) begin
            code        = gpio_sync[i*IN_W +: IN_W];
            cand_nxt[i] = candidate[i];
            cnt_nxt[i]  = stable_cnt[i];
            acc_nxt[i]  = accepted[i];
            if (code == candidate[i]) begin
                if (stable_cnt[i] < 4'(STABLE_SAMPLES))
                    cnt_nxt[i] = stable_cnt[i] + 4'd1;
            end else begin
                cand_nxt[i] = code;
                cnt_nxt[i]  = 4'd1;
            end
            if (cnt_nxt[i] == 4'(STABLE_SAMPLES))
                acc_nxt[i] = cand_nxt[i];

            prod      = CMP_W'(acc_nxt[i]) * CMP_W'(STEP);
            sat       = (prod > CMP_W'(MAX_OUT)) ? CMP_W'(MAX_OUT) : prod;
            target[i] = OUT_W'(sat);
            cur       = value[i*OUT_W +: OUT_W];
            diff      = '0;
`ifdef EXTERNAL_CONTROLS_SLEW_EN
            if (target[i] > cur) begin
                diff         = CMP_W'(target[i] - cur);
                value_nxt[i] = (diff > CMP_W'(SLEW)) ? cur + OUT_W'(SLEW) : target[i];
            end else begin
                diff         = CMP_W'(cur - target[i]);
                value_nxt[i] = (diff > CMP_W'(SLEW)) ? cur - OUT_W'(SLEW) : target[i];
            end
`else
            value_nxt[i] = (diff == '0) ? target[i] : cur;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value   <= '0;
            update  <= 1'b0;
            changed <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                candidate[i]  <= '0;
                accepted[i]   <= '0;
                stable_cnt[i] <= '0;
            end
        end else begin
            update  <= tick;
            changed <= '0;
            if (tick) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    candidate[i]               <= cand_nxt[i];
                    stable_cnt[i]              <= cnt_nxt[i];
                    accepted[i]                <= acc_nxt[i];
                    value[i*OUT_W +: OUT_W]    <= value_nxt[i];
                    changed[i]                 <= (value_nxt[i] != value[i*OUT_W +: OUT_W]);
                end
            end
        end
    end

endmodule
